// File: rtl/sram_sp_arbiter_pkg.sv
// Shared types and default widths for the single-port SRAM arbiter.
// The optional init sweep is enabled with SRAM_SP_ARBITER_INIT_EN.
package sram_sp_arbiter_pkg;

    localparam int ADDR_W_DEF = 11;
    localparam int DATA_W_DEF = 36;
    localparam int MASK_W_DEF = 6;

    // Grant vector bit positions
    localparam int GNT_RD = 0;
    localparam int GNT_WR = 1;

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_SERVE = 1'b1
    } state_t;

    typedef struct packed {
        logic [ADDR_W_DEF-1:0] addr;
    } rd_req_t;

    typedef struct packed {
        logic [ADDR_W_DEF-1:0] addr;
        logic [MASK_W_DEF-1:0] mask;
        logic [DATA_W_DEF-1:0] data;
    } wr_req_t;

endpackage

// File: rtl/sram_sp_arbiter_rr.sv
// Two-input round-robin arbiter: bit 0 = read, bit 1 = write, one-hot grant.
module sram_rr_arb2
    import sram_sp_arbiter_pkg::*;
(
    input  logic       i_clock,
    input  logic       i_reset_n,
    input  logic [1:0] i_valid,
    output logic [1:0] o_grant
);

    logic r_lastRd;

    // On contention favour whichever side did not win last; read wins first after reset
    always_comb begin
        o_grant = 2'b00;
        case (i_valid)
            2'b01:   o_grant = 2'b01;
            2'b10:   o_grant = 2'b10;
            2'b11:   o_grant = r_lastRd ? 2'b10 : 2'b01;
            default: o_grant = 2'b00;
        endcase
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_lastRd <= 1'b0;
        end else if (|o_grant) begin
            r_lastRd <= o_grant[GNT_RD];
        end
    end

endmodule

// File: rtl/sram_sp_arbiter.sv
// Shares one single-port SRAM between a read and a masked-write requester.
// Define SRAM_SP_ARBITER_INIT_EN to sweep INIT_VALUE into every entry after reset.
module sram_sp_arbiter
    import sram_sp_arbiter_pkg::*;
#(
    parameter int              ADDR_W     = ADDR_W_DEF,
    parameter int              DATA_W     = DATA_W_DEF,
    parameter int              MASK_W     = MASK_W_DEF,
    parameter logic [DATA_W-1:0] INIT_VALUE = '0
) (
    input  logic              i_clock,
    input  logic              i_reset_n,
    input  logic              i_rd_valid,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic              o_rd_ready,
    input  logic              i_wr_valid,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [MASK_W-1:0] i_wr_mask,
    input  logic [DATA_W-1:0] i_wr_data,
    output logic              o_wr_ready,
    output logic              o_resp_valid,
    output logic [DATA_W-1:0] o_resp_data,
    output logic              o_init_done,
    output logic              o_sram_en,
    output logic              o_sram_wmode,
    output logic [ADDR_W-1:0] o_sram_addr,
    output logic [MASK_W-1:0] o_sram_wmask,
    output logic [DATA_W-1:0] o_sram_wdata,
    input  logic [DATA_W-1:0] i_sram_rdata
);

    logic              r_initDone;
    logic              r_rdPend;
    logic [DATA_W-1:0] r_respHold;
    logic [1:0]        w_grant;
    logic              w_initActive;
    logic [ADDR_W-1:0] w_initAddr;
    logic [DATA_W-1:0] w_initWord;

    assign w_initWord = INIT_VALUE;

`ifdef SRAM_SP_ARBITER_INIT_EN
    state_t            r_state;
    state_t            w_stateNext;
    logic [ADDR_W-1:0] r_initCnt;

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state <= ST_INIT;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        if (r_state == ST_INIT && r_initCnt == {ADDR_W{1'b1}}) begin
            w_stateNext = ST_SERVE;
        end
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_initCnt  <= '0;
            r_initDone <= 1'b0;
        end else begin
            if (r_state == ST_INIT) begin
                r_initCnt <= r_initCnt + 1'b1;
            end
            r_initDone <= (w_stateNext == ST_SERVE);
        end
    end

    // Reset gates the sweep so the macro is idle while reset is held
    assign w_initActive = (r_state == ST_INIT) && i_reset_n;
    assign w_initAddr   = r_initCnt;
`else
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_initDone <= 1'b0;
        end else begin
            r_initDone <= 1'b1;
        end
    end

    assign w_initActive = 1'b0;
    assign w_initAddr   = '0;
`endif

    sram_rr_arb2 u_arb (
        .i_clock   (i_clock),
        .i_reset_n (i_reset_n),
        .i_valid   ({i_wr_valid, i_rd_valid} & {2{r_initDone}}),
        .o_grant   (w_grant)
    );

    assign o_rd_ready  = w_grant[GNT_RD];
    assign o_wr_ready  = w_grant[GNT_WR];
    assign o_init_done = r_initDone;

    always_comb begin
        o_sram_en    = 1'b0;
        o_sram_wmode = 1'b0;
        o_sram_addr  = '0;
        o_sram_wmask = '0;
        o_sram_wdata = '0;
        if (w_initActive) begin
            o_sram_en    = 1'b1;
            o_sram_wmode = 1'b1;
            o_sram_addr  = w_initAddr;
            o_sram_wmask = '1;
            o_sram_wdata = w_initWord;
        end else if (w_grant[GNT_RD]) begin
            o_sram_en    = 1'b1;
            o_sram_addr  = i_rd_addr;
        end else if (w_grant[GNT_WR]) begin
            o_sram_en    = 1'b1;
            o_sram_wmode = 1'b1;
            o_sram_addr  = i_wr_addr;
            o_sram_wmask = i_wr_mask;
            o_sram_wdata = i_wr_data;
        end
    end

    // Response data passes straight through on the pulse and is held afterwards
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_rdPend   <= 1'b0;
            r_respHold <= '0;
        end else begin
            r_rdPend <= i_rd_valid && w_grant[GNT_RD];
            if (r_rdPend) begin
                r_respHold <= i_sram_rdata;
            end
        end
    end

    assign o_resp_valid = r_rdPend;
    assign o_resp_data  = r_rdPend ? i_sram_rdata : r_respHold;

endmodule
